clk_display_scan: RTL and testbench

Time-multiplexed display driver directly downstream of the 12-hour clock core. It takes the six decoded 7-segment digit buses plus the AM/PM flag and drives the six right-hand digits of an 8-digit common-anode display. The display has a shared, active-low segment bus and active-low anodes. A blanking gap between digits suppresses ghosting, and an optional blink marks set-time mode.

---
 rtl/clk_display_scan.sv | 102 ++++++++++
 tb/tb_clk_display_scan.sv | 120 ++++++++++++
 2 files changed

// File: rtl/clk_display_scan.sv
// clk_display_scan: six-digit time-multiplexed 7-segment driver with inter-digit blanking.
// Optional set-time blink enabled by defining CLK_DISP_BLINK_EN.
module clk_display_scan #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DIGIT_HZ  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sec1_seg,
  input  logic [6:0] sec10_seg,
  input  logic [6:0] min1_seg,
  input  logic [6:0] min10_seg,
  input  logic [6:0] hour1_seg,
  input  logic [6:0] hour10_seg,
  input  logic       am_pm,
  input  logic       set_time,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CW = $clog2(DWELL);

  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [6:0] sh_seg, sh_seg_n, sel_seg, seg_n;
  logic sh_dp, sh_dp_n, sel_dp, dp_n;
  logic [7:0] an_n;
  logic wrap, latch, lit, on;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= BLANK;
      cnt    <= '0;
      idx    <= '0;
      sh_seg <= 7'h7F;
      sh_dp  <= 1'b1;
      an     <= 8'hFF;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh_seg <= sh_seg_n;
      sh_dp  <= sh_dp_n;
      an     <= an_n;
      seg    <= seg_n;
      dp     <= dp_n;
    end

  // Outputs are registered from next-state values so each flop shows the cycle it belongs to.
  always_comb begin
    wrap     = cnt == CW'(DWELL - 1);
    cnt_n    = wrap ? '0 : cnt + 1'b1;
    idx_n    = wrap ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
    state_n  = cnt_n >= CW'(BLANK_CYC) ? SHOW : BLANK;
    sel_seg  = idx == 3'd0 ? sec1_seg  : idx == 3'd1 ? sec10_seg :
               idx == 3'd2 ? min1_seg  : idx == 3'd3 ? min10_seg :
               idx == 3'd4 ? hour1_seg : hour10_seg;
    sel_dp   = idx == 3'd0 ? ~am_pm : (idx == 3'd2 || idx == 3'd4) ? 1'b0 : 1'b1;
    latch    = state == BLANK && cnt == CW'(BLANK_CYC - 1);
    sh_seg_n = latch ? sel_seg : sh_seg;
    sh_dp_n  = latch ? sel_dp : sh_dp;
    lit      = state_n == SHOW && on;
    an_n     = lit ? ~(8'd1 << idx_n) : 8'hFF;
    seg_n    = lit ? sh_seg_n : 7'h7F;
    dp_n     = lit ? sh_dp_n : 1'b1;
  end

`ifdef CLK_DISP_BLINK_EN
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW = $clog2(HALF + 1);
  logic [BW-1:0] bcnt, bcnt_n;
  logic phase, phase_n, b_wrap;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else begin
      bcnt  <= bcnt_n;
      phase <= phase_n;
    end

  always_comb begin
    b_wrap  = bcnt == BW'(HALF - 1);
    bcnt_n  = !set_time || b_wrap ? '0 : bcnt + 1'b1;
    phase_n = !set_time ? 1'b1 : b_wrap ? ~phase : phase;
  end

  assign on = !(set_time && !phase_n);
`else
  logic unused_blink;
  assign unused_blink = set_time & (BLINK_HZ != 0);
  assign on = 1'b1;
`endif
endmodule

// File: tb/tb_clk_display_scan.sv
// tb_clk_display_scan: scoreboard bench for clk_display_scan (DWELL=10, BLANK_CYC=2, blink half-period 10).
module tb_clk_display_scan;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] s1, s10, m1, m10, h1, h10;
  logic am_pm, set_time;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;

  int checks = 0, errors = 0;
  int n = 0, run = 0;
  logic [6:0] sh_seg = 7'h7F;
  logic sh_dp = 1'b1;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  clk_display_scan #(.CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYC(2), .BLINK_HZ(50)) dut (
    .clk(clk), .reset(reset),
    .sec1_seg(s1), .sec10_seg(s10), .min1_seg(m1), .min10_seg(m10),
    .hour1_seg(h1), .hour10_seg(h10),
    .am_pm(am_pm), .set_time(set_time),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] src_of(int d);
    return d == 0 ? s1 : d == 1 ? s10 : d == 2 ? m1 : d == 3 ? m10 : d == 4 ? h1 : h10;
  endfunction

  task automatic compare_out();
    logic [15:0] e;
    e = sb.pop_front();
    check("an", an, e[15:8]);
    check("seg", seg, e[7:1]);
    check("dp", dp, e[0]);
  endtask

  // Called #1 after a rising edge; reset is asserted and checked mid-cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    #1 reset = 1'b0;
    sb.delete();
    n = 0;
    run = 0;
    sh_seg = 7'h7F;
    sh_dp = 1'b1;
    sb.push_back({8'hFF, 7'h7F, 1'b1});
    compare_out();
  endtask

  task automatic step();
    int c, d, m, dm;
    logic off;
    c = n % 10;
    d = (n / 10) % 6;
    if (c == 1) begin
      sh_seg = src_of(d);
      sh_dp = d == 0 ? ~am_pm : (d == 2 || d == 4) ? 1'b0 : 1'b1;
    end
    run = set_time ? run + 1 : 0;
    m = n + 1;
    dm = (m / 10) % 6;
    off = (m % 10) < 2;
`ifdef CLK_DISP_BLINK_EN
    off = off || (set_time && ((run / 10) % 2 == 1));
`endif
    sb.push_back(off ? {8'hFF, 7'h7F, 1'b1} : {~(8'd1 << dm), sh_seg, sh_dp});
    @(posedge clk);
    #1;
    n++;
    compare_out();
  endtask

  initial begin
    s1 = 7'h40; s10 = 7'h79; m1 = 7'h24; m10 = 7'h30; h1 = 7'h19; h10 = 7'h12;
    am_pm = 1'b1;
    set_time = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 130; i++) begin
      if (n == 5) s1 = 7'h79;
      step();
    end
    set_time = 1'b0;
    am_pm = 1'b0;
    s1 = 7'h40;
    @(posedge clk);
    #1;
    do_reset();
    while (n < 25) step();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: s1 = 7'($urandom);
        1: s10 = 7'($urandom);
        2: m1 = 7'($urandom);
        3: h10 = 7'($urandom);
        default: ;
      endcase
      if (n % 37 == 0) am_pm = ~am_pm;
      if (n % 45 == 0) set_time = 1'($urandom_range(0, 1));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
